uart_rx_8n1: RTL

- UART receiver, 8 data bits, no parity, 1 stop bit, LSB first. Counterpart to the existing 8N1 transmitter.
- Runs directly on the 12 MHz system clock. It generates its own 16x-oversample tick internally, so no derived baud clock is needed.
- Output is a byte plus a one-cycle valid strobe, for use by top-level logic (e.g. loopback/echo, LED control from the FTDI line).

---
 rtl/uart_rx_8n1.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampled, 2-of-3 majority vote at mid-bit, byte + one-cycle strobe.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit before the stop bit and adds parity_err.
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16,
    parameter int DIV      = CLK_FREQ / (BAUD * OVS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic          rx_meta, rx_s, rx_s_d;
    logic [DW-1:0] div_cnt;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    smp;
    logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    logic       tick, fall, decide, maj;
    logic [3:0] os_nxt;

    assign tick   = (div_cnt == DIV_LAST);
    assign os_nxt = os_cnt + 4'd1;
    assign fall   = rx_s_d & ~rx_s;
    // Bit value is settled on the tick that advances os_cnt to 9; the third vote is the live rx_s.
    assign decide = tick && (os_nxt == 4'd9);
    assign maj    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_d     <= 1'b1;
            div_cnt    <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            smp        <= '0;
            shift      <= '0;
            rxbyte     <= 8'h00;
            rxvalid    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_d    <= rx_s;
            rxvalid   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                os_cnt <= os_nxt;
                if (os_nxt == 4'd7) smp[0] <= rx_s;
                if (os_nxt == 4'd8) smp[1] <= rx_s;
            end

            case (state)
                IDLE: begin
                    // Restart the divider so bit timing is anchored to the start edge.
                    if (fall) begin
                        state   <= START;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        os_cnt  <= '0;
                    end
                end
                START: begin
                    if (decide) begin
                        if (maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift   <= {maj, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= PARITY;
`else
                        if (bit_cnt == 3'd7) state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) begin
                        par_bad <= ^{shift, maj};
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                    if (decide) begin
                        if (maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) parity_err <= 1'b1;
                            else
`endif
                            begin
                                rxbyte  <= shift;
                                rxvalid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
